// File: rtl/pq_cmd_pkg.sv
// Shared types for the hybrid_tree priority-queue command sequencer.
package pq_cmd_pkg;

    localparam int PQ_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        PQ_ENQUEUE = 2'd0,
        PQ_DEQUEUE = 2'd1,
        PQ_REPLACE = 2'd2,
        PQ_PEEK    = 2'd3
    } pq_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_RESPOND = 2'd3
    } pq_state_t;

    // The key field follows PQ_DATA_WIDTH; the top's DATA_WIDTH must match it.
    typedef struct packed {
        pq_op_t                   op;
        logic [PQ_DATA_WIDTH-1:0] data;
    } pq_req_t;

endpackage

// File: rtl/pq_cmd_sequencer_fifo.sv
// Request buffer for the sequencer: synchronous FIFO of pq_req_t with a
// registered not-full flag (ready) and a combinational empty flag.
module pq_req_fifo
    import pq_cmd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  pq_req_t push_data,
    input  logic    pop,
    output pq_req_t pop_data,
    output logic    empty,
    output logic    ready
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pq_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_next;

    always_comb begin
        count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/pq_cmd_sequencer.sv
// Command front-end for the hybrid_tree max-first priority queue: buffers
// requests, pulses i_wrt/i_read once per op, waits out the settle window, responds.
module pq_cmd_sequencer
    import pq_cmd_pkg::*;
#(
    parameter int DATA_WIDTH    = PQ_DATA_WIDTH,
    parameter int SETTLE_CYCLES = 24,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [1:0]            o_rsp_op,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data,
    output logic                  o_busy
);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    pq_state_t             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  boot_q, boot_d;
    pq_req_t               cmd_q, cmd_d;
    pq_op_t                rsp_op_q, rsp_op_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  pq_wrt_q, pq_wrt_d;
    logic                  pq_read_q, pq_read_d;
    logic [DATA_WIDTH-1:0] pq_data_q, pq_data_d;

    pq_req_t fifo_in;
    pq_req_t fifo_head;
    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_empty;

    // Handshake: a request transfers on a rising CLK where i_req_valid && o_req_ready;
    // a response transfers where o_rsp_valid && i_rsp_ready, and o_rsp_* hold until then.
    always_comb begin
        fifo_in.op   = pq_op_t'(i_req_op);
        fifo_in.data = i_req_data;
    end

    assign fifo_push = i_req_valid && o_req_ready;

    pq_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RSTn),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .ready     (o_req_ready)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        boot_d     = boot_q;
        cmd_d      = cmd_q;
        rsp_op_d   = rsp_op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        pq_data_d  = pq_data_q;
        pq_wrt_d   = 1'b0;
        pq_read_d  = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_head;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_op_d   = cmd_q.op;
                rsp_data_d = i_pq_data;
                rsp_err_d  = 1'b0;
                cnt_d      = SETTLE_LOAD;
                state_d    = ST_RESPOND;
                case (cmd_q.op)
                    PQ_ENQUEUE: begin
                        rsp_data_d = '0;
                        if (i_pq_full) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            pq_wrt_d  = 1'b1;
                            pq_data_d = cmd_q.data;
                            state_d   = ST_SETTLE;
                        end
                    end
                    PQ_DEQUEUE: begin
                        if (i_pq_empty) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            pq_read_d = 1'b1;
                            state_d   = ST_SETTLE;
                        end
                    end
                    PQ_REPLACE: begin
                        if (i_pq_empty) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            pq_wrt_d  = 1'b1;
                            pq_read_d = 1'b1;
                            pq_data_d = cmd_q.data;
                            state_d   = ST_SETTLE;
                        end
                    end
                    default: rsp_err_d = i_pq_empty;
                endcase
                if (rsp_err_d) rsp_data_d = '0;
            end
            ST_SETTLE: begin
                // The post-reset settle only waits for queue init; there is nothing to answer.
                if (cnt_q == '0) begin
                    state_d = boot_q ? ST_IDLE : ST_RESPOND;
                    boot_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (i_rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        cmd_d    = fifo_head;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= SETTLE_LOAD;
            boot_q     <= 1'b1;
            cmd_q      <= '0;
            rsp_op_q   <= PQ_ENQUEUE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            pq_wrt_q   <= 1'b0;
            pq_read_q  <= 1'b0;
            pq_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            boot_q     <= boot_d;
            cmd_q      <= cmd_d;
            rsp_op_q   <= rsp_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            pq_wrt_q   <= pq_wrt_d;
            pq_read_q  <= pq_read_d;
            pq_data_q  <= pq_data_d;
        end
    end

    assign o_rsp_valid = (state_q == ST_RESPOND);
    assign o_rsp_op    = rsp_op_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_pq_wrt    = pq_wrt_q;
    assign o_pq_read   = pq_read_q;
    assign o_pq_data   = pq_data_q;
    assign o_busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Directed bench for pq_cmd_sequencer against a behavioural max-first queue
// of capacity 12; responses are checked by a scoreboard monitor.
module tb_pq_cmd_sequencer;
    import pq_cmd_pkg::*;

    localparam int DW     = 16;
    localparam int SETTLE = 24;
    localparam int DEPTH  = 4;
    localparam int QCAP   = 12;
    localparam int EW     = 2 + DW + 1;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [1:0]    i_req_op = 2'd0;
    logic [DW-1:0] i_req_data = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b1;
    logic [1:0]    o_rsp_op;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_err;
    logic          o_pq_wrt;
    logic          o_pq_read;
    logic [DW-1:0] o_pq_data;
    logic          i_pq_full = 1'b0;
    logic          i_pq_empty = 1'b1;
    logic [DW-1:0] i_pq_data = '0;
    logic          o_busy;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] mdl[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wrt_cnt = 0;
    int read_cnt = 0;
    int last_pulse = -1;
    logic          held = 1'b0;
    logic [EW-1:0] held_rsp;
    logic [EW-1:0] cur_rsp;

    pq_cmd_sequencer #(
        .DATA_WIDTH    (DW),
        .SETTLE_CYCLES (SETTLE),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_op    (i_req_op),
        .i_req_data  (i_req_data),
        .o_rsp_valid (o_rsp_valid),
        .i_rsp_ready (i_rsp_ready),
        .o_rsp_op    (o_rsp_op),
        .o_rsp_data  (o_rsp_data),
        .o_rsp_err   (o_rsp_err),
        .o_pq_wrt    (o_pq_wrt),
        .o_pq_read   (o_pq_read),
        .o_pq_data   (o_pq_data),
        .i_pq_full   (i_pq_full),
        .i_pq_empty  (i_pq_empty),
        .i_pq_data   (i_pq_data),
        .o_busy      (o_busy)
    );

    // Clock and reset-relative cycle counter
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RSTn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Behavioural max-first queue: contents kept sorted, largest first
    always @(posedge CLK) begin
        if (o_pq_wrt && o_pq_read) begin
            if (mdl.size() > 0) void'(mdl.pop_front());
            mdl.push_back(o_pq_data);
            mdl.rsort();
        end else if (o_pq_wrt) begin
            if (mdl.size() < QCAP) begin
                mdl.push_back(o_pq_data);
                mdl.rsort();
            end
        end else if (o_pq_read) begin
            if (mdl.size() > 0) void'(mdl.pop_front());
        end
        i_pq_full  <= (mdl.size() >= QCAP);
        i_pq_empty <= (mdl.size() == 0);
        i_pq_data  <= (mdl.size() > 0) ? mdl[0] : '0;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic check_rsp(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got op=%0d data=0x%0h err=%0d, expected op=%0d data=0x%0h err=%0d",
                     name, got[EW-1 -: 2], got[DW:1], got[0], want[EW-1 -: 2], want[DW:1], want[0]);
        end
    endtask

    // Driver: present one request and wait for acceptance
    task automatic send(input pq_op_t op, input logic [DW-1:0] key,
                        input logic [DW-1:0] exp_data, input logic exp_err, input bit keep);
        int guard;
        guard = 0;
        @(negedge CLK);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_data  = key;
        while (!o_req_ready && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        if (!o_req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_accept: o_req_ready low for %0d cycles, required 1", guard);
        end else begin
            if (keep) exp_q.push_back({op, exp_data, exp_err});
            @(negedge CLK);
        end
        i_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((o_busy || o_rsp_valid || exp_q.size() != 0) && guard < 3000) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0d pending=%0d after %0d cycles, required idle",
                     o_busy, exp_q.size(), guard);
        end
    endtask

    task automatic measure_latency(output int n);
        n = 0;
        while (!o_rsp_valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
    endtask

    pq_op_t        ops2 [6] = '{PQ_ENQUEUE, PQ_ENQUEUE, PQ_ENQUEUE, PQ_DEQUEUE, PQ_DEQUEUE, PQ_DEQUEUE};
    logic [DW-1:0] key2 [6] = '{16'd5, 16'd900, 16'd17, 16'd0, 16'd0, 16'd0};
    logic [DW-1:0] exp2 [6] = '{16'd0, 16'd0, 16'd0, 16'd900, 16'd17, 16'd5};
    logic [DW-1:0] fill [QCAP] = '{16'd1020, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90,
                                   16'd100, 16'd110, 16'd120, 16'd130, 16'd140, 16'd150};
    pq_op_t        ops5 [5] = '{PQ_PEEK, PQ_DEQUEUE, PQ_PEEK, PQ_DEQUEUE, PQ_PEEK};
    logic [DW-1:0] exp5 [5] = '{16'd1000, 16'd1000, 16'd150, 16'd150, 16'd140};

    initial begin
        int n;
        int r0;
        int w0;

        // Scoreboard monitor and pulse checker
        fork
            forever begin
                @(negedge CLK);
                if (!RSTn) begin
                    held       = 1'b0;
                    last_pulse = -1;
                end else begin
                    if (o_pq_wrt || o_pq_read) begin
                        if (o_pq_wrt)  wrt_cnt++;
                        if (o_pq_read) read_cnt++;
                        if (last_pulse >= 0) begin
                            n_cmp++;
                            if (cyc - last_pulse < SETTLE + 1) begin
                                n_err++;
                                $display("FAIL pulse_spacing: gap %0d cycles, required >= %0d",
                                         cyc - last_pulse, SETTLE + 1);
                            end
                        end
                        last_pulse = cyc;
                    end
                    if (o_rsp_valid) begin
                        cur_rsp = {o_rsp_op, o_rsp_data, o_rsp_err};
                        if (held) check_rsp("rsp_stable", cur_rsp, held_rsp);
                        if (i_rsp_ready) begin
                            if (exp_q.size() == 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL unexpected_rsp: got op=%0d data=0x%0h err=%0d, required no response",
                                         o_rsp_op, o_rsp_data, o_rsp_err);
                            end else begin
                                check_rsp("rsp", cur_rsp, exp_q.pop_front());
                            end
                            held = 1'b0;
                        end else begin
                            held     = 1'b1;
                            held_rsp = cur_rsp;
                        end
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        join_none

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_req_ready", o_req_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_err",   o_rsp_err,   0);
        check("rst_rsp_op",    o_rsp_op,    0);
        check("rst_rsp_data",  o_rsp_data,  0);
        check("rst_pq_wrt",    o_pq_wrt,    0);
        check("rst_pq_read",   o_pq_read,   0);
        check("rst_pq_data",   o_pq_data,   0);
        check("rst_busy",      o_busy,      1);

        // Request during the post-reset settle window
        @(posedge CLK); #1 RSTn = 1'b1;
        send(PQ_ENQUEUE, 16'h0123, 16'h0, 1'b0, 1'b1);
        n = 0;
        while (!o_pq_wrt && n < 200) begin
            @(negedge CLK);
            n++;
        end
        n_cmp++;
        if (cyc < SETTLE + 1 || cyc > SETTLE + 2) begin
            n_err++;
            $display("FAIL boot_wrt_cycle: first o_pq_wrt at cycle %0d, required %0d..%0d",
                     cyc, SETTLE + 1, SETTLE + 2);
        end
        check("boot_wrt_data", o_pq_data, 16'h0123);
        measure_latency(n);
        check("boot_rsp_cycle", cyc, 2 * SETTLE + 2);
        wait_idle();

        // Issued op latency, acceptance to response
        send(PQ_DEQUEUE, 16'h0, 16'h0123, 1'b0, 1'b1);
        measure_latency(n);
        check("issued_latency", n, SETTLE + 2);
        wait_idle();

        // Ordering through the real queue behaviour
        for (int i = 0; i < 6; i++) send(ops2[i], key2[i], exp2[i], 1'b0, 1'b1);
        wait_idle();

        // Empty-queue errors
        r0 = read_cnt;
        send(PQ_DEQUEUE, 16'h0, 16'h0, 1'b1, 1'b1);
        measure_latency(n);
        check("deq_empty_latency", n, 2);
        wait_idle();
        send(PQ_PEEK, 16'h0, 16'h0, 1'b1, 1'b1);
        measure_latency(n);
        check("peek_empty_latency", n, 2);
        wait_idle();
        check("no_read_on_err", read_cnt, r0);

        // Full queue, then REPLACE and PEEK
        for (int i = 0; i < QCAP; i++) send(PQ_ENQUEUE, fill[i], 16'h0, 1'b0, 1'b1);
        wait_idle();
        w0 = wrt_cnt;
        send(PQ_ENQUEUE, 16'd7, 16'h0, 1'b1, 1'b1);
        measure_latency(n);
        check("enq_full_latency", n, 2);
        wait_idle();
        check("no_wrt_on_full", wrt_cnt, w0);
        send(PQ_REPLACE, 16'd1000, 16'd1020, 1'b0, 1'b1);
        send(PQ_PEEK, 16'h0, 16'd1000, 1'b0, 1'b1);
        wait_idle();

        // Back-pressure on the response side
        @(posedge CLK); #1 i_rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(ops5[i], 16'h0, exp5[i], 1'b0, 1'b1);
        check("req_ready_full", o_req_ready, 0);
        r0 = read_cnt;
        repeat (10) @(negedge CLK);
        check("no_issue_held", read_cnt, r0);
        check("rsp_held_valid", o_rsp_valid, 1);
        @(posedge CLK); #1 i_rsp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of a DEQUEUE settle, with requests still buffered
        send(PQ_DEQUEUE, 16'h0, 16'd140, 1'b0, 1'b0);
        send(PQ_PEEK, 16'h0, 16'd130, 1'b0, 1'b0);
        send(PQ_PEEK, 16'h0, 16'd130, 1'b0, 1'b0);
        repeat (5) @(negedge CLK);
        @(posedge CLK); #1 RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("mid_rst_rsp_valid", o_rsp_valid, 0);
        check("mid_rst_pq_read",   o_pq_read,   0);
        check("mid_rst_pq_wrt",    o_pq_wrt,    0);
        check("mid_rst_req_ready", o_req_ready, 0);
        check("mid_rst_busy",      o_busy,      1);
        @(posedge CLK); #1 RSTn = 1'b1;
        send(PQ_PEEK, 16'h0, 16'd130, 1'b0, 1'b1);
        measure_latency(n);
        check("reset_rsp_cycle", cyc, SETTLE + 2);
        wait_idle();

        check("total_wrt_pulses",  wrt_cnt,  17);
        check("total_read_pulses", read_cnt, 8);
        check("exp_drained",       exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pq_cmd_sequencer.md
Name: pq_cmd_sequencer

Overview:
Upstream command front-end for the hybrid_tree priority queue (max-first, ports i_wrt/i_read/i_data, o_full/o_empty/o_data). Accepts ENQUEUE/DEQUEUE/REPLACE/PEEK requests over a valid/ready handshake and buffers them in a small FIFO. Issues each request to the queue as a single-cycle i_wrt/i_read pulse, then holds off for the queue's fixed settle window. Returns exactly one response per accepted request, carrying the removed or peeked value, or an error flag.

Parameters:
DATA_WIDTH, 16, key width; matches the hybrid_tree DATA_WIDTH.
SETTLE_CYCLES, 24, cycles the queue needs after a write/read pulse before o_data, o_full and o_empty are valid again.
FIFO_DEPTH, 4, request buffer entries; power of two, at least 2.

Ports:
CLK  in  1  clock
RSTn  in  1  synchronous active-low reset
i_req_valid  in  1  request valid
o_req_ready  out  1  request accepted when valid && ready
i_req_op  in  2  0 ENQUEUE, 1 DEQUEUE, 2 REPLACE, 3 PEEK
i_req_data  in  DATA_WIDTH  key for ENQUEUE/REPLACE
o_rsp_valid  out  1  response valid; held until accepted
i_rsp_ready  in  1  response consumer ready
o_rsp_op  out  2  echo of the request op
o_rsp_data  out  DATA_WIDTH  root value sampled at issue (DEQUEUE/REPLACE/PEEK); 0 for ENQUEUE or error
o_rsp_err  out  1  request rejected (full/empty violation)
o_pq_wrt  out  1  to hybrid_tree i_wrt
o_pq_read  out  1  to hybrid_tree i_read
o_pq_data  out  DATA_WIDTH  to hybrid_tree i_data
i_pq_full  in  1  from hybrid_tree o_full
i_pq_empty  in  1  from hybrid_tree o_empty
i_pq_data  in  DATA_WIDTH  from hybrid_tree o_data (current max)
o_busy  out  1  FSM not in IDLE, or FIFO non-empty

Behaviour:
- Clock and reset: one clock CLK; reset RSTn is synchronous and active-low.
- Reset values:
  - o_req_ready=0 during reset; 1 from the first cycle after reset deassertion.
  - o_rsp_valid, o_rsp_err, o_pq_wrt, o_pq_read = 0; o_rsp_data, o_rsp_op, o_pq_data = 0; o_busy=1.
  - FIFO emptied.
  - FSM enters SETTLE with counter = SETTLE_CYCLES-1, so the first issue waits for queue init.
- Request FIFO:
  - o_req_ready = !fifo_full (registered).
  - A push on the cycle the FIFO is full is impossible, because ready is low.
  - Push and pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, SETTLE, RESPOND.
- IDLE: FIFO non-empty -> ISSUE (pop the head into the command register).
- ISSUE (one cycle):
  - Evaluate i_pq_full/i_pq_empty and capture i_pq_data into o_rsp_data.
  - ENQUEUE: if !full, o_pq_wrt=1 and o_pq_data=key -> SETTLE. If full, err=1 -> RESPOND.
  - DEQUEUE: if !empty, o_pq_read=1 -> SETTLE. If empty, err=1 -> RESPOND.
  - REPLACE: if !empty, o_pq_wrt=1, o_pq_read=1, o_pq_data=key -> SETTLE. If empty, err=1 -> RESPOND.
  - PEEK: no pulse; err = empty -> RESPOND.
  - Pulses are high for exactly one cycle. Never both low-then-high within a single op.
- SETTLE: counter starts at SETTLE_CYCLES-1 and decrements. At 0 -> RESPOND, or -> IDLE when settling after reset.
- RESPOND:
  - o_rsp_valid=1; op/data/err held stable until i_rsp_ready.
  - On the handshake: FIFO non-empty -> ISSUE directly; else -> IDLE.
- Latency, head of FIFO to o_rsp_valid:
  - Issued op: 1+SETTLE_CYCLES cycles.
  - Error or PEEK: 1 cycle.
- Back-to-back spacing between issue pulses is at least SETTLE_CYCLES+1 cycles.
- Errored requests never touch the queue. o_rsp_data=0 when err=1.
- Reset mid-SETTLE or mid-RESPOND: pending response and FIFO contents are discarded, outputs return to reset values, and the SETTLE wait restarts.
- Response ordering equals request acceptance order.

Decomposition:
- Package pq_cmd_pkg:
  - typedef enum logic [1:0] pq_op_t {PQ_ENQUEUE, PQ_DEQUEUE, PQ_REPLACE, PQ_PEEK}.
  - typedef enum for FSM states.
  - Packed struct pq_req_t {op, data}.
- Sub-module pq_req_fifo: synchronous FIFO of pq_req_t, FIFO_DEPTH entries, with full/empty flags.

Test Plan:
- Reset release, request issued during the SETTLE window -> no o_pq_wrt pulse until cycle SETTLE_CYCLES after reset; then a single 1-cycle o_pq_wrt with o_pq_data=0x0123.
- With the real hybrid_tree (QUEUE_SIZE=12, ARRAY_SIZE=4), ENQUEUE 5, 900, 17 then DEQUEUE x3 -> responses ENQUEUE x3 (err=0, data=0), then data 900, 17, 5. Issue pulses are spaced at least 25 cycles apart.
- DEQUEUE and PEEK on an empty queue -> o_rsp_err=1, o_rsp_data=0, no o_pq_read pulse, response 1 cycle after issue.
- Fill to 12 entries, then ENQUEUE 7 -> err=1, no o_pq_wrt. Follow with REPLACE 1000 with root 1020 -> rsp data=1020. Next PEEK -> 1000 (1000 is the largest remaining key).
- Hold i_rsp_ready=0 while pushing 5 requests -> o_req_ready falls after the FIFO fills. Response held stable with no new issue. Release ready -> responses drain in order.
- Assert RSTn=0 mid-SETTLE of a DEQUEUE -> o_rsp_valid and o_pq_* stay 0, FIFO empty, and the post-reset settle wait repeats.
